// File: rtl/pipes.sv
// Shared pipeline types for the five-stage MIPS core: inter-stage registers,
// fetch-stage FSM encoding and the default reset vector.
package pipes;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus_4;
  } f_d_reg_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues valid/data_ok requests to
// instruction memory and fills the F/D register, honouring late redirects.
module fetch_unit
  import pipes::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        fd_valid,
  output f_d_reg_t    fd,
  output logic [31:0] pc_f
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  f_d_reg_t     fd_q, fd_d;
  logic         fd_valid_q, fd_valid_d;
  logic [31:0]  pc_plus_4;

  assign pc_plus_4 = next_seq_pc(pc_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          state_d = iresp_data_ok ? FETCH : DRAIN;
        end else if (iresp_data_ok && stallF) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || !stallF) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (iresp_data_ok) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // DRAIN keeps presenting the old PC: the request must stay stable until acked.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = pc_q;
    unique case (state_q)
      FETCH:   ireq_valid = 1'b1;
      DRAIN:   ireq_valid = 1'b1;
      HOLD:    ireq_valid = 1'b0;
      default: ireq_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= PC_RESET;
      pending_pc_q <= 32'd0;
      hold_instr_q <= 32'd0;
      fd_q         <= '0;
      fd_valid_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      hold_instr_q <= hold_instr_d;
      fd_q         <= fd_d;
      fd_valid_q   <= fd_valid_d;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    hold_instr_d = hold_instr_q;
    fd_d         = fd_q;
    fd_valid_d   = fd_valid_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (iresp_data_ok) begin
            pc_d = redirect_pc;
          end else begin
            pending_pc_d = redirect_pc;
          end
        end else if (iresp_data_ok) begin
          if (stallF) begin
            hold_instr_d = iresp_data;
          end else begin
            fd_d.instruction = iresp_data;
            fd_d.pc_plus_4   = pc_plus_4;
            fd_valid_d       = 1'b1;
            pc_d             = pc_plus_4;
          end
        end else if (!stallF) begin
          fd_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (!stallF) begin
          fd_d.instruction = hold_instr_q;
          fd_d.pc_plus_4   = pc_plus_4;
          fd_valid_d       = 1'b1;
          pc_d             = pc_plus_4;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pending_pc_d = redirect_pc;
        end
        if (iresp_data_ok) begin
          pc_d = redirect_valid ? redirect_pc : pending_pc_q;
        end
      end
      default: ;
    endcase
    // A redirect flushes the wrong-path instruction ahead of any other update.
    if (redirect_valid) begin
      fd_valid_d = 1'b0;
    end
  end

  assign fd       = fd_q;
  assign fd_valid = fd_valid_q;
  assign pc_f     = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: per-cycle input records with
// hand-computed request and F/D expectations, plus an async reset sequence.
module tb_fetch_unit;
  import pipes::*;

  logic        clk;
  logic        reset;
  logic        stallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        fd_valid;
  f_d_reg_t    fd;
  logic [31:0] pc_f;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ok;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_fdv;
    logic [31:0] exp_instr;
    logic [31:0] exp_p4;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.PC_RESET(32'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stallF         (stallF),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .fd_valid       (fd_valid),
    .fd             (fd),
    .pc_f           (pc_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic stall, input logic redir, input logic [31:0] rpc,
                                 input logic ok, input logic [31:0] data,
                                 input logic exp_req, input logic [31:0] exp_addr,
                                 input logic exp_fdv, input logic [31:0] exp_instr,
                                 input logic [31:0] exp_p4);
    vec_t v;
    v.stall = stall; v.redir = redir; v.rpc = rpc; v.ok = ok; v.data = data;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_fdv = exp_fdv;
    v.exp_instr = exp_instr; v.exp_p4 = exp_p4;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc,
                               input logic ok, input logic [31:0] data);
    stallF         = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    iresp_data_ok  = ok;
    iresp_data     = data;
  endtask

  initial begin
    string tag;
    // Columns: stall redir rpc ok data | req addr | fdv instr pc_plus_4
    addVec(0, 0, 0, 1, 32'h9111_1111, 1, 32'h8000_0000, 1, 32'h9111_1111, 32'h8000_0004);
    addVec(0, 0, 0, 1, 32'h9111_1115, 1, 32'h8000_0004, 1, 32'h9111_1115, 32'h8000_0008);
    addVec(0, 0, 0, 1, 32'h9111_1119, 1, 32'h8000_0008, 1, 32'h9111_1119, 32'h8000_000C);
    addVec(1, 0, 0, 1, 32'h2008_0005, 1, 32'h8000_000C, 1, 32'h9111_1119, 32'h8000_000C);
    addVec(1, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h9111_1119, 32'h8000_000C);
    addVec(1, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h9111_1119, 32'h8000_000C);
    addVec(0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 1, 32'h8000_0100, 0, 32'h0, 1, 32'h8000_0010, 0, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h8000_0010, 0, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h8000_0010, 0, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 0, 0, 0, 32'h0,         1, 32'h8000_0100, 0, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 1, 32'h8000_0200, 0, 32'h0, 1, 32'h8000_0100, 0, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 1, 32'h8000_0300, 0, 32'h0, 1, 32'h8000_0100, 0, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 0, 0, 1, 32'hBAD0_0000, 1, 32'h8000_0100, 0, 32'h2008_0005, 32'h8000_0010);
    addVec(0, 0, 0, 1, 32'h1234_5678, 1, 32'h8000_0300, 1, 32'h1234_5678, 32'h8000_0304);
    addVec(0, 1, 32'hFFFF_FFFC, 1, 32'h9111_1015, 1, 32'h8000_0304, 0, 32'h1234_5678, 32'h8000_0304);
    addVec(0, 0, 0, 1, 32'hEEEE_EEED, 1, 32'hFFFF_FFFC, 1, 32'hEEEE_EEED, 32'h0000_0000);
    addVec(1, 1, 32'h8000_0400, 1, 32'h1111_1111, 1, 32'h0000_0000, 0, 32'hEEEE_EEED, 32'h0000_0000);
    addVec(0, 0, 0, 1, 32'h9111_1511, 1, 32'h8000_0400, 1, 32'h9111_1511, 32'h8000_0404);
    addVec(1, 0, 0, 1, 32'hAAAA_AAAA, 1, 32'h8000_0404, 1, 32'h9111_1511, 32'h8000_0404);
    addVec(1, 1, 32'h8000_0500, 0, 32'h0, 0, 32'h0, 0, 32'h9111_1511, 32'h8000_0404);
    addVec(0, 0, 0, 1, 32'h5555_5555, 1, 32'h8000_0500, 1, 32'h5555_5555, 32'h8000_0504);

    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    checkOutput("reset_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    checkOutput("reset_ireq_addr", ireq_addr, 32'h8000_0000);
    checkOutput("reset_fd_valid", {31'd0, fd_valid}, 32'd0);
    checkOutput("reset_fd_instr", fd.instruction, 32'd0);
    checkOutput("reset_fd_p4", fd.pc_plus_4, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ok, vecs[i].data);
      #1;
      tag = $sformatf("v%0d", i);
      checkOutput({tag, "_ireq_valid"}, {31'd0, ireq_valid}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) begin
        checkOutput({tag, "_ireq_addr"}, ireq_addr, vecs[i].exp_addr);
        checkOutput({tag, "_pc_f"}, pc_f, vecs[i].exp_addr);
      end
      @(posedge clk);
      #1;
      checkOutput({tag, "_fd_valid"}, {31'd0, fd_valid}, {31'd0, vecs[i].exp_fdv});
      checkOutput({tag, "_fd_instr"}, fd.instruction, vecs[i].exp_instr);
      checkOutput({tag, "_fd_p4"}, fd.pc_plus_4, vecs[i].exp_p4);
    end

    // Enter DRAIN with an outstanding request, then reset between clock edges.
    @(negedge clk);
    applyStimulus(0, 1, 32'h8000_0600, 0, 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drain_ireq_valid", {31'd0, ireq_valid}, 32'd1);
    checkOutput("drain_ireq_addr", ireq_addr, 32'h8000_0504);
    checkOutput("drain_fd_instr_kept", fd.instruction, 32'h5555_5555);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_fd_valid", {31'd0, fd_valid}, 32'd0);
    checkOutput("async_rst_fd_instr", fd.instruction, 32'd0);
    checkOutput("async_rst_ireq_addr", ireq_addr, 32'h8000_0000);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 32'h9111_1111);
    #1;
    checkOutput("post_rst_ireq_addr", ireq_addr, 32'h8000_0000);
    @(posedge clk);
    #1;
    checkOutput("post_rst_fd_valid", {31'd0, fd_valid}, 32'd1);
    checkOutput("post_rst_fd_instr", fd.instruction, 32'h9111_1111);
    checkOutput("post_rst_fd_p4", fd.pc_plus_4, 32'h8000_0004);
    checkOutput("post_rst_next_addr", ireq_addr, 32'h8000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. Owns the program counter and issues instruction requests to instruction memory with a valid/data_ok handshake. Fills the F/D pipeline register (`f_d_reg_t`) consumed by decode. Applies branch/jump redirects from later stages, including redirects that arrive while a memory request is still outstanding.

## Interface
Parameters:
- `PC_RESET`, default `32'h8000_0000`: PC value loaded on reset.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stallF`  in  1  from the hazard unit; decode cannot accept a new instruction this cycle.
- `redirect_valid`  in  1  a taken branch or jump resolved downstream.
- `redirect_pc`  in  32  target address of the redirect.
- `ireq_valid`  out  1  instruction request valid.
- `ireq_addr`  out  32  instruction request address.
- `iresp_data_ok`  in  1  the response for the current request is present this cycle (may arrive in the same cycle as the request).
- `iresp_data`  in  32  instruction word; valid when `iresp_data_ok`=1.
- `fd_valid`  out  1  the F/D register holds a real instruction. When 0, decode sees a bubble.
- `fd`  out  `f_d_reg_t`  F/D register contents: `{instruction, pc_plus_4}`.
- `pc_f`  out  32  current fetch PC, for debug and `pcs_t`.

## Operation
The stage is a three-state FSM: FETCH, HOLD, DRAIN. Registers are `pc`, `pending_pc`, `hold_instr`, `fd`, `fd_valid` and `state`.

- **FETCH**
  - Outputs: `ireq_valid`=1, `ireq_addr`=`pc`.
  - `redirect_valid` with `data_ok`: discard the response. `pc`<=`redirect_pc`. Stay in FETCH.
  - `redirect_valid` without `data_ok`: `pending_pc`<=`redirect_pc`. Go to DRAIN.
  - `data_ok`, no redirect, `!stallF`: `fd`<={`iresp_data`, `pc`+4}, `fd_valid`<=1, `pc`<=`pc`+4.
  - `data_ok`, no redirect, `stallF`: `hold_instr`<=`iresp_data`. Go to HOLD. `fd` is unchanged.
  - No `data_ok`, `!stallF`: `fd_valid`<=0 (bubble).
  - No `data_ok`, `stallF`: `fd` is unchanged.
- **HOLD**
  - Outputs: `ireq_valid`=0.
  - `redirect_valid`: drop `hold_instr`. `pc`<=`redirect_pc`. Go to FETCH.
  - Else `!stallF`: `fd`<={`hold_instr`, `pc`+4}, `fd_valid`<=1, `pc`<=`pc`+4. Go to FETCH.
  - Else: stay in HOLD.
- **DRAIN**
  - Outputs: `ireq_valid`=1, `ireq_addr`=old `pc`. The request stays stable until it is acknowledged.
  - A further `redirect_valid` overwrites `pending_pc`; the latest redirect wins.
  - On `data_ok`: discard the response. `pc`<=`pending_pc` (or `redirect_pc` if a redirect is present that cycle). Go to FETCH.
- **Redirect effect on F/D:** any cycle with `redirect_valid`=1 sets `fd_valid`<=0. This flushes the wrong-path instruction, overrides `stallF`, and has priority over every other `fd` update.
- **Request stability:** `ireq_addr` never changes while `ireq_valid`=1 and the request is unacknowledged.
- **PC arithmetic:** `pc`+4 wraps modulo 2^32; `32'hFFFF_FFFC` becomes `32'h0000_0000`. No alignment check is made; `redirect_pc` is used as-is.

## Timing
- **Reset (asynchronous):** `pc`=`PC_RESET`, `pending_pc`=0, `hold_instr`=0, `fd`=0, `fd_valid`=0, state=FETCH.
- **Requests during and after reset:**
  - `ireq_valid` is 1 combinationally from the FETCH state, so it is 1 during reset with `ireq_addr`=`PC_RESET`.
  - Memory is reset together with this block, so a `data_ok` in the first cycle after release belongs to `PC_RESET`.
- **Reset mid-operation:** the outstanding request, any pending redirect and any held instruction are abandoned with no further effect.
- **Latency:** the F/D register updates at the clock edge that ends a cycle with `data_ok`=1 and `stallF`=0. With zero-wait memory, throughput is one instruction per cycle.
- **Redirect penalty:** the first instruction from the target appears in `fd` one edge after the target's `data_ok`.
  - From FETCH or HOLD, the target request is issued in the cycle after the redirect.
  - From DRAIN, the target request is issued one cycle after the old response arrives.
- **Simultaneous events:**
  - Redirect and `data_ok` in the same cycle: the response is always discarded.
  - Redirect and `stallF` in the same cycle: redirect wins.

## Structure
- Add `fetch_state_t` (enum: FETCH, HOLD, DRAIN) to `pipes`.
- Add the `PC_RESET` default constant to `pipes`.
- Reuse `f_d_reg_t` from `pipes` for the `fd` output.
- Single module with no sub-module; the FSM and PC register together are small enough.

## Test plan
- **Reset and zero-wait stream:** memory returns `data_ok` every cycle with instr = addr ^ `32'h1111_1111`.
  - Requests go to `0x8000_0000`, `0x8000_0004`, `0x8000_0008`.
  - `fd` shows matching instructions with `pc_plus_4` = `0x8000_0004`, `0x8000_0008`, `0x8000_000C` on consecutive edges.
- **Stall with data:** `stallF`=1 for 3 cycles while `data_ok` returns `0x2008_0005`.
  - State is HOLD, `ireq_valid`=0, `fd` is unchanged.
  - On release, `fd.instruction`=`0x2008_0005` and the next request goes to `pc`+4.
- **Redirect during wait:** memory has 3-cycle latency for the request to `0x8000_0010`; `redirect_valid` with `0x8000_0100` arrives in the request's first cycle.
  - `ireq_addr` stays `0x8000_0010` until `data_ok`, and that response is discarded.
  - The next request is to `0x8000_0100`, and `fd_valid`=0 throughout.
- **Double redirect in DRAIN:** redirects to `0x8000_0200`, then `0x8000_0300`, both before `data_ok` → the next request is `0x8000_0300`.
- **Wrap and simultaneity:** redirect to `0xFFFF_FFFC` with zero-wait memory.
  - `fd.pc_plus_4`=`0x0000_0000` and the next request is to `0x0`.
  - A redirect coinciding with `data_ok` and `stallF`=1 leaves `fd_valid`=0 and the next request at the redirect target.
- **Reset mid-DRAIN:** assert `reset` asynchronously in DRAIN → `fd_valid` drops immediately, and after release the first request is to `0x8000_0000`.
